mem_arbiter: RTL and testbench

//  Two-requester arbiter in front of the single memory port of the SRAM

---
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (C = processor, D = DMA/IO) in front of one memory port.
// Single outstanding transaction, bounded C streak while D waits, and a bus timeout.
module mem_arbiter #(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 36,
   parameter int MAX_CONSEC = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_write_data,
   input  logic              c_read,
   input  logic              c_write,
   input  logic              c_user,
   output logic [DATA_W-1:0] c_read_data,
   output logic              c_ack,
   output logic              c_err,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_write_data,
   input  logic              d_read,
   input  logic              d_write,
   input  logic              d_user,
   output logic [DATA_W-1:0] d_read_data,
   output logic              d_ack,
   output logic              d_err,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_write_data,
   output logic              m_read,
   output logic              m_write,
   output logic              m_user,
   input  logic [DATA_W-1:0] m_read_data,
   input  logic              m_ack,
   output logic              m_owner
);

   localparam int SW = $clog2(MAX_CONSEC + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CONSEC);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_write_data_q, m_write_data_d;
   logic              m_read_q, m_read_d, m_write_q, m_write_d;
   logic              m_user_q, m_user_d, m_owner_q, m_owner_d;
   logic [DATA_W-1:0] c_read_data_q, c_read_data_d, d_read_data_q, d_read_data_d;
   logic              c_ack_q, c_ack_d, c_err_q, c_err_d;
   logic              d_ack_q, d_ack_d, d_err_q, d_err_d;

   logic              c_pend, d_pend, grant_d, own_req;
   logic              fin, fin_err;
   logic [DATA_W-1:0] fin_data;

   always_comb begin
      state_d        = state_q;
      streak_d       = streak_q;
      tmo_d          = tmo_q;
      m_addr_d       = m_addr_q;
      m_write_data_d = m_write_data_q;
      m_read_d       = m_read_q;
      m_write_d      = m_write_q;
      m_user_d       = m_user_q;
      m_owner_d      = m_owner_q;
      c_read_data_d  = c_read_data_q;
      c_ack_d        = c_ack_q;
      c_err_d        = c_err_q;
      d_read_data_d  = d_read_data_q;
      d_ack_d        = d_ack_q;
      d_err_d        = d_err_q;
      fin            = 1'b0;
      fin_err        = 1'b0;
      fin_data       = '0;

      c_pend  = c_read | c_write;
      d_pend  = d_read | d_write;
      grant_d = d_pend & (~c_pend | (streak_q >= STREAK_MAX));
      own_req = m_owner_q ? d_pend : c_pend;

      unique case (state_q)
         IDLE: begin
            if (c_pend | d_pend) begin
               state_d        = BUSY;
               tmo_d          = '0;
               m_owner_d      = grant_d;
               m_addr_d       = grant_d ? d_addr       : c_addr;
               m_write_data_d = grant_d ? d_write_data : c_write_data;
               m_user_d       = grant_d ? d_user       : c_user;
               m_write_d      = grant_d ? d_write      : c_write;
               m_read_d       = grant_d ? (d_read & ~d_write) : (c_read & ~c_write);
               // Streak only grows while C is beating a waiting D.
               if (!grant_d && d_pend)
                  streak_d = (streak_q >= STREAK_MAX) ? streak_q : streak_q + 1'b1;
               else
                  streak_d = '0;
            end
         end
         BUSY: begin
            if (m_ack) begin
               fin      = 1'b1;
               fin_data = m_read_q ? m_read_data : '0;
            end else if (tmo_q == TMO_LAST) begin
               fin     = 1'b1;
               fin_err = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DONE: begin
            if (!m_ack && !own_req) begin
               state_d       = IDLE;
               c_ack_d       = 1'b0;
               c_err_d       = 1'b0;
               c_read_data_d = '0;
               d_ack_d       = 1'b0;
               d_err_d       = 1'b0;
               d_read_data_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (fin) begin
         state_d   = DONE;
         m_read_d  = 1'b0;
         m_write_d = 1'b0;
         if (m_owner_q) begin
            d_ack_d       = 1'b1;
            d_err_d       = fin_err;
            d_read_data_d = fin_data;
         end else begin
            c_ack_d       = 1'b1;
            c_err_d       = fin_err;
            c_read_data_d = fin_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         streak_q       <= '0;
         tmo_q          <= '0;
         m_addr_q       <= '0;
         m_write_data_q <= '0;
         m_read_q       <= 1'b0;
         m_write_q      <= 1'b0;
         m_user_q       <= 1'b0;
         m_owner_q      <= 1'b0;
         c_read_data_q  <= '0;
         c_ack_q        <= 1'b0;
         c_err_q        <= 1'b0;
         d_read_data_q  <= '0;
         d_ack_q        <= 1'b0;
         d_err_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         streak_q       <= streak_d;
         tmo_q          <= tmo_d;
         m_addr_q       <= m_addr_d;
         m_write_data_q <= m_write_data_d;
         m_read_q       <= m_read_d;
         m_write_q      <= m_write_d;
         m_user_q       <= m_user_d;
         m_owner_q      <= m_owner_d;
         c_read_data_q  <= c_read_data_d;
         c_ack_q        <= c_ack_d;
         c_err_q        <= c_err_d;
         d_read_data_q  <= d_read_data_d;
         d_ack_q        <= d_ack_d;
         d_err_q        <= d_err_d;
      end
   end

   assign m_addr       = m_addr_q;
   assign m_write_data = m_write_data_q;
   assign m_read       = m_read_q;
   assign m_write      = m_write_q;
   assign m_user       = m_user_q;
   assign m_owner      = m_owner_q;
   assign c_read_data  = c_read_data_q;
   assign c_ack        = c_ack_q;
   assign c_err        = c_err_q;
   assign d_read_data  = d_read_data_q;
   assign d_ack        = d_ack_q;
   assign d_err        = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand sequences for fairness, timeout, overlapping requests, reset and held ack.
module tb_mem_arbiter;

   logic        clk, reset_n;
   logic [17:0] c_addr, d_addr, m_addr;
   logic [35:0] c_write_data, d_write_data, m_write_data;
   logic        c_read, c_write, c_user, d_read, d_write, d_user;
   logic [35:0] c_read_data, d_read_data, m_read_data;
   logic        c_ack, c_err, d_ack, d_err;
   logic        m_read, m_write, m_user, m_owner, m_ack;

   mem_arbiter #(.ADDR_W(18), .DATA_W(36), .MAX_CONSEC(4), .TIMEOUT(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .c_addr(c_addr), .c_write_data(c_write_data), .c_read(c_read), .c_write(c_write),
      .c_user(c_user), .c_read_data(c_read_data), .c_ack(c_ack), .c_err(c_err),
      .d_addr(d_addr), .d_write_data(d_write_data), .d_read(d_read), .d_write(d_write),
      .d_user(d_user), .d_read_data(d_read_data), .d_ack(d_ack), .d_err(d_err),
      .m_addr(m_addr), .m_write_data(m_write_data), .m_read(m_read), .m_write(m_write),
      .m_user(m_user), .m_read_data(m_read_data), .m_ack(m_ack), .m_owner(m_owner)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   int inv   = 0;
   bit mon_en = 1'b0;

   // Memory model controls
   int          lat     = 5;
   bit          noack   = 1'b0;
   bit          mdl_en  = 1'b1;
   bit          man_ack = 1'b0;
   logic [35:0] rdval   = '0;

   typedef struct {
      bit          who;
      bit          rd;
      bit          wr;
      bit          user;
      logic [17:0] addr;
      logic [35:0] wdata;
      logic [35:0] mem;
      bit          exp_mr;
      bit          exp_mw;
      logic [35:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic wait_ack(input bit who, input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc && !ok; i++) begin
         @(negedge clk);
         if (who ? d_ack : c_ack) ok = 1'b1;
      end
   endtask

   task automatic drop_all;
      c_read = 0; c_write = 0; d_read = 0; d_write = 0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      bit ok;
      rdval = v.mem;
      if (v.who) begin
         d_addr = v.addr; d_write_data = v.wdata; d_user = v.user; d_read = v.rd; d_write = v.wr;
      end else begin
         c_addr = v.addr; c_write_data = v.wdata; c_user = v.user; c_read = v.rd; c_write = v.wr;
      end
      @(negedge clk);
      check($sformatf("v%0d_mread", idx), m_read, v.exp_mr);
      check($sformatf("v%0d_mwrite", idx), m_write, v.exp_mw);
      check($sformatf("v%0d_owner", idx), m_owner, v.who);
      check($sformatf("v%0d_maddr", idx), m_addr, v.addr);
      check($sformatf("v%0d_muser", idx), m_user, v.user);
      check($sformatf("v%0d_mwdata", idx), m_write_data, v.wdata);
      wait_ack(v.who, 30, ok);
      check($sformatf("v%0d_ackseen", idx), ok, 1);
      check($sformatf("v%0d_rdata", idx), v.who ? d_read_data : c_read_data, v.exp_rdata);
      check($sformatf("v%0d_err", idx), v.who ? d_err : c_err, 0);
      check($sformatf("v%0d_other", idx),
            v.who ? {c_ack, c_err, c_read_data} : {d_ack, d_err, d_read_data}, 0);
      check($sformatf("v%0d_mdrop", idx), {m_read, m_write}, 0);
      drop_all();
      @(negedge clk);
      check($sformatf("v%0d_ackclr", idx), {c_ack, d_ack}, 0);
   endtask

   // Memory model: counts busy cycles and raises m_ack for one cycle after lat.
   initial begin
      int cnt;
      cnt = 0;
      m_ack = 1'b0;
      m_read_data = '0;
      forever begin
         @(posedge clk);
         #2;
         m_read_data = rdval;
         if (!mdl_en) m_ack = man_ack;
         else if (!reset_n || !(m_read | m_write)) begin
            m_ack = 1'b0;
            cnt = 0;
         end else if (!m_ack) begin
            cnt++;
            if (cnt >= lat && !noack) m_ack = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (m_read & m_write) inv++;
         if (c_ack & d_ack) inv++;
         if (m_owner ? (c_ack | c_err | (c_read_data != 0))
                     : (d_ack | d_err | (d_read_data != 0))) inv++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int grants, ov, cyc, held, busy;
      bit prev;

      vecs[0] = '{0, 1, 0, 0, 18'o1000, 36'o0,   36'o123456701234, 1, 0, 36'o123456701234};
      vecs[1] = '{0, 0, 1, 1, 18'o2000, 36'o777, 36'o555,          0, 1, 36'o0};
      vecs[2] = '{0, 1, 1, 0, 18'o3000, 36'o42,  36'o666,          0, 1, 36'o0};
      vecs[3] = '{1, 1, 0, 1, 18'o4000, 36'o0,   36'o707070707070, 1, 0, 36'o707070707070};
      vecs[4] = '{1, 0, 1, 0, 18'o17,   36'o31,  36'o444,          0, 1, 36'o0};
      vecs[5] = '{1, 1, 1, 1, 18'o5000, 36'o77,  36'o333,          0, 1, 36'o0};

      reset_n = 1'b0;
      c_addr = '0; c_write_data = '0; c_user = 0;
      d_addr = '0; d_write_data = '0; d_user = 0;
      drop_all();
      repeat (3) @(negedge clk);
      check("rst_mctl", {m_read, m_write, m_owner, m_user}, 0);
      check("rst_acks", {c_ack, c_err, d_ack, d_err}, 0);
      check("rst_data", {c_read_data, d_read_data}, 0);
      check("rst_maddr", {m_addr, m_write_data}, 0);
      reset_n = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Fairness under continuous contention
      c_addr = 18'o100; c_write_data = 36'o1; d_addr = 18'o200; d_write_data = 36'o2;
      lat = 2; grants = 0; ov = 0; prev = 1'b0;
      for (int k = 0; k < 400 && grants < 10; k++) begin
         c_write = ~c_ack;
         d_write = ~d_ack;
         @(negedge clk);
         if (c_ack & d_ack) ov++;
         if ((m_read | m_write) && !prev) begin
            check($sformatf("fair_g%0d", grants), m_owner, (grants % 5) == 4);
            grants++;
         end
         prev = m_read | m_write;
      end
      drop_all();
      repeat (15) @(negedge clk);
      check("fair_count", grants, 10);
      check("fair_overlap", ov, 0);

      // Timeout on a D read that never acks
      lat = 5; noack = 1'b1; rdval = 36'o525252525252;
      d_addr = 18'o7000; d_user = 0; d_read = 1'b1;
      @(negedge clk);
      check("tmo_grant", {m_read, m_owner}, 2'b11);
      cyc = 0; ok = 1'b0;
      while (!ok && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (d_ack) ok = 1'b1;
      end
      check("tmo_cycles", cyc, 64);
      check("tmo_err", d_err, 1);
      check("tmo_rdata", d_read_data, 0);
      check("tmo_mread", m_read, 0);
      check("tmo_cack", c_ack, 0);
      d_read = 1'b0; noack = 1'b0;
      @(negedge clk);
      check("tmo_clr", {d_ack, d_err}, 0);
      run_vec(6, vecs[0]);

      // D arrives while C is busy and while C holds its request in DONE
      c_addr = 18'o600; c_write_data = 36'o12; c_write = 1'b1;
      @(negedge clk);
      check("ovl_cgrant", {m_write, m_owner}, 2'b10);
      d_addr = 18'o601; d_read = 1'b1; rdval = 36'o2222;
      wait_ack(0, 30, ok);
      check("ovl_cack", ok, 1);
      busy = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (m_read | m_write | d_ack) busy++;
      end
      check("ovl_noearly", busy, 0);
      c_write = 1'b0;
      @(negedge clk);
      check("ovl_gap", {m_read, m_write, c_ack}, 0);
      @(negedge clk);
      check("ovl_dgrant", {m_read, m_owner, m_addr}, {2'b11, 18'o601});
      wait_ack(1, 30, ok);
      check("ovl_dack", {ok, d_read_data}, {1'b1, 36'o2222});
      d_read = 1'b0;
      @(negedge clk);

      // Reset in the middle of a busy read; later m_ack must be ignored
      noack = 1'b1; c_addr = 18'o1234; c_user = 1'b1; c_read = 1'b1;
      @(negedge clk);
      check("rb_busy", m_read, 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b0; c_read = 1'b0;
      @(negedge clk);
      check("rb_mctl", {m_read, m_write, m_owner, m_user}, 0);
      check("rb_out", {c_ack, c_err, d_ack, d_err, m_addr}, 0);
      reset_n = 1'b1; noack = 1'b0;
      mdl_en = 1'b0; man_ack = 1'b1;
      repeat (3) @(negedge clk);
      check("rb_stray_ack", {m_read, m_write, c_ack, d_ack, c_err, d_err}, 0);
      man_ack = 1'b0;
      @(negedge clk);
      mdl_en = 1'b1;

      // Owner keeps its request 10 cycles after ack
      rdval = 36'o4321; c_addr = 18'o55; c_user = 1'b0; c_read = 1'b1;
      wait_ack(0, 30, ok);
      check("hold_ack", ok, 1);
      held = 0; busy = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (c_ack) held++;
         if (m_read | m_write) busy++;
      end
      check("hold_cycles", held, 10);
      check("hold_nogrant", busy, 0);
      check("hold_rdata", c_read_data, 36'o4321);
      c_read = 1'b0;
      @(negedge clk);
      check("hold_release", {c_ack, m_read, m_write}, 0);

      check("invariants", inv, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
